// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed FIFO controller: geometry of the
// 16x8 single-port RAM and the encodings of the fetch state machine.
package ram_fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  // Fetch FSM: IDLE may launch a RAM read, WAIT captures the read data.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM with a registered read.
// Reads (fetches into the output register) take priority over writes on the
// shared RAM port; the output register adds one word of capacity on top of
// the RAM, for 17 words in total.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = ram_fifo_pkg::DATA_W,
  parameter int ADDR_W = ram_fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              fetch;
  logic              wr_en;

  // Status flags come from registers only, never from the stream handshakes.
  assign count     = count_q;
  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0) && (state_q == ST_IDLE) && !out_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ram_din   = in_data;

  // Port arbitration and next-state computation for pointers, count, FSM and
  // the output register.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // A fetch is launched only from IDLE, when a word is resident and the
    // output register is free or being emptied this cycle.
    fetch    = !rst && (state_q == ST_IDLE) && (count_q != '0) &&
               (!out_valid_q || out_ready);
    // Reads own the port in fetch cycles; in_ready never looks at in_valid.
    in_ready = !rst && !full && !fetch;
    wr_en    = in_valid && in_ready;

    ram_we   = wr_en;
    ram_addr = rst ? '0 : (fetch ? rd_ptr_q : wr_ptr_q);

    if (fetch) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
      state_d  = ST_WAIT;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end

    if (state_q == ST_WAIT) begin
      // The RAM read launched last cycle is valid now; a pop of the old word
      // in this same cycle is superseded by the new capture.
      state_d     = ST_IDLE;
      out_valid_d = 1'b1;
      out_data_d  = ram_dout;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; RAM contents are untouched and
  // any in-flight fetch is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before this edge.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl wired to a behavioural 16x8
// single-port RAM with registered read.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Behavioural single-port RAM: write when we=1, registered read otherwise.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else        ram_dout <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic iv, input logic [7:0] id, input logic ordy);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  // Offer one word with out_ready=0, holding it until accepted (bounded).
  task automatic write_word(input logic [7:0] d, input string name);
    int n;
    drive(1'b0, 1'b1, d, 1'b0);
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [7:0] pat(input int k);
    logic [7:0] first [3];
    first[0] = 8'hFF;
    first[1] = 8'h3C;
    first[2] = 8'hA5;
    if (k < 3) return first[k];
    return 8'((k * 13 + 7) & 8'hFF);
  endfunction

  typedef struct packed {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       chk;
    logic       e_in_ready;
    logic       e_ram_we;
    logic [3:0] e_ram_addr;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_out_valid;
    logic [7:0] e_out_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [21:0] act;
    logic [21:0] exp;
    logic [7:0]  q[$];
    logic [7:0]  e;
    int idx, last, cyc, sent, recv;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    // Reset, then a single word 0xA5 written with out_ready=0 and popped.
    //           rst  iv  id     ordy chk ir  we  addr  cnt    emp f  ov  data
    vecs[0] = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,4'd0,5'd0,1'b1,1'b0,1'b0,8'h00};
    vecs[1] = '{1'b1,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,4'd0,5'd0,1'b1,1'b0,1'b0,8'h00};
    vecs[2] = '{1'b0,1'b1,8'hA5,1'b0,1'b1,1'b1,1'b1,4'd0,5'd0,1'b1,1'b0,1'b0,8'h00};
    vecs[3] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,4'd0,5'd1,1'b0,1'b0,1'b0,8'h00};
    vecs[4] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,4'd1,5'd0,1'b0,1'b0,1'b0,8'h00};
    vecs[5] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,4'd1,5'd0,1'b0,1'b0,1'b1,8'hA5};
    vecs[6] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0,4'd1,5'd0,1'b0,1'b0,1'b1,8'hA5};
    vecs[7] = '{1'b0,1'b0,8'h00,1'b0,1'b1,1'b1,1'b0,4'd1,5'd0,1'b1,1'b0,1'b0,8'h00};

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].id, vecs[i].ordy);
      if (vecs[i].chk) begin
        act = {in_ready, ram_we, ram_addr, count, empty, full, out_valid,
               (out_valid ? out_data : 8'h00)};
        exp = {vecs[i].e_in_ready, vecs[i].e_ram_we, vecs[i].e_ram_addr,
               vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full,
               vecs[i].e_out_valid, vecs[i].e_out_data};
        check($sformatf("vec%0d", i), {10'd0, act}, {10'd0, exp});
      end
    end

    // Fill: 17 words 0x00..0x10 with out_ready=0; the first lands in the
    // output register, the other 16 fill the RAM.
    for (int i = 0; i < 17; i++) write_word(8'(i), $sformatf("fill_accept%0d", i));
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {27'd0, count}, 32'd16);
    check("fill_head", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h00});
    for (int i = 0; i < 3; i++) begin
      check($sformatf("full_reject%0d", i), {27'd0, count, in_ready}, {27'd0, 5'd16, 1'b0});
      drive(1'b0, 1'b1, 8'h3C, 1'b0);
    end

    // Drain: expect 0x00..0x10 in order, one pop every 2 cycles, then empty.
    idx = 0; last = 0; cyc = 0;
    while (idx < 17 && cyc < 100) begin
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      if (out_valid) begin
        check($sformatf("drain_data%0d", idx), {24'd0, out_data}, 32'(idx));
        if (idx > 0) check($sformatf("drain_gap%0d", idx), 32'(cyc - last), 32'd2);
        last = cyc;
        idx++;
      end
      cyc++;
    end
    check("drain_done", 32'(idx), 32'd17);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("drain_empty", {26'd0, empty, count}, {26'd0, 1'b1, 5'd0});

    // Concurrent traffic: both sides always willing, 100 words end to end.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 100 && cyc < 2000) begin
      drive(1'b0, sent < 100, pat(sent), 1'b1);
      if (in_valid && !in_ready)
        check("conc_stall_only_on_fetch", {31'd0, count != 5'd0 && !full}, 32'd1);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("conc_spurious", {24'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check($sformatf("conc_data%0d", recv), {24'd0, out_data}, {24'd0, e});
        end
        recv++;
      end
      cyc++;
    end
    check("conc_count", 32'(recv), 32'd100);
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    check("conc_empty", {31'd0, empty}, 32'd1);

    // Reset while a fetch is in WAIT with 5 words resident.
    for (int i = 0; i < 6; i++) write_word(8'h11 + 8'(i), $sformatf("pre_rst_wr%0d", i));
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    check("pre_rst_state", {26'd0, out_valid, count}, {26'd0, 1'b1, 5'd5});
    drive(1'b0, 1'b0, 8'h00, 1'b1);   // pop + fetch
    drive(1'b1, 1'b0, 8'h00, 1'b0);   // WAIT cycle, reset asserted
    check("rst_we_low", {31'd0, ram_we}, 32'd0);
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    check("post_rst", {28'd0, out_valid, count == 5'd0, empty, in_ready},
          {28'd0, 1'b0, 1'b1, 1'b1, 1'b1});
    cyc = 0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    while (!out_valid && cyc < 10) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      cyc++;
    end
    check("post_rst_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h5A});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
